// File: rtl/uart_loader_pkg.sv
// rtl/uart_loader_pkg.sv - shared types and constants for the UART program loader
package uart_loader_pkg;

   typedef enum logic [2:0] {
      LD_IDLE  = 3'd0,
      LD_LEN   = 3'd1,
      LD_DATA  = 3'd2,
      LD_CSUM  = 3'd3,
      LD_FLUSH = 3'd4,
      LD_DONE  = 3'd5,
      LD_ERROR = 3'd6
   } loader_state_t;

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_LEN     = 2'd1;
   localparam logic [1:0] ERR_OVERRUN = 2'd2;
   localparam logic [1:0] ERR_CSUM    = 2'd3;

   // Byte enables for a word whose highest filled lane is 'lane'.
   function automatic logic [3:0] lane_mask(input logic [1:0] lane);
      logic [3:0] m;
      case (lane)
         2'd0:    m = 4'b0001;
         2'd1:    m = 4'b0011;
         2'd2:    m = 4'b0111;
         default: m = 4'b1111;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/uart_loader_if.sv
// rtl/uart_loader_if.sv - valid/ready memory write port of the UART program loader
interface uart_loader_if;

   logic        mem_valid;
   logic        mem_ready;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wmask;

   modport master (
      output mem_valid,
      output mem_addr,
      output mem_wdata,
      output mem_wmask,
      input  mem_ready
   );

   modport slave (
      input  mem_valid,
      input  mem_addr,
      input  mem_wdata,
      input  mem_wmask,
      output mem_ready
   );

endinterface

// File: rtl/uart_loader_wbuf.sv
// rtl/uart_loader_wbuf.sv - single-entry write holding register driving the memory port
module uart_loader_wbuf #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic [31:0] addr,
   input  logic [31:0] data,
   input  logic [3:0]  mask,
   output logic        full,
   output logic        mem_valid,
   input  logic        mem_ready,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wmask
);

   logic        valid_q, valid_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] data_q, data_d;
   logic [3:0]  mask_q, mask_d;

   // The caller only loads when empty or when the held write retires this
   // cycle, so the fields never change under a pending request.
   always_comb begin
      valid_d = valid_q;
      addr_d  = addr_q;
      data_d  = data_q;
      mask_d  = mask_q;
      if (load) begin
         valid_d = 1'b1;
         addr_d  = addr;
         data_d  = data;
         mask_d  = mask;
      end else if (valid_q && mem_ready) begin
         valid_d = 1'b0;
      end
   end

   // Holding register with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         addr_q  <= BASE_ADDR;
         data_q  <= 32'd0;
         mask_q  <= 4'd0;
      end else begin
         valid_q <= valid_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         mask_q  <= mask_d;
      end
   end

   assign full      = valid_q;
   assign mem_valid = valid_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = data_q;
   assign mem_wmask = mask_q;

endmodule

// File: rtl/uart_loader.sv
// rtl/uart_loader.sv - UART byte-stream image loader (optional checksum: UART_LOADER_CHECKSUM_EN)
module uart_loader
   import uart_loader_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter logic [31:0] MAX_BYTES = 32'h0001_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   input  logic        start,
   uart_loader_if.master mem,
   output logic        busy,
   output logic        done,
   output logic [1:0]  error
);

   localparam logic [2:0] S_IDLE  = LD_IDLE;
   localparam logic [2:0] S_LEN   = LD_LEN;
   localparam logic [2:0] S_DATA  = LD_DATA;
   localparam logic [2:0] S_CSUM  = LD_CSUM;
   localparam logic [2:0] S_FLUSH = LD_FLUSH;
   localparam logic [2:0] S_DONE  = LD_DONE;
   localparam logic [2:0] S_ERROR = LD_ERROR;

`ifdef UART_LOADER_CHECKSUM_EN
   localparam logic [2:0] S_AFTER = S_CSUM;
`else
   localparam logic [2:0] S_AFTER = S_FLUSH;
`endif

   logic [2:0]  state_q, state_d;
   logic [31:0] len_q, len_d;
   logic [31:0] cnt_q, cnt_d;
   logic [1:0]  bidx_q, bidx_d;
   logic [31:0] asm_q, asm_d;
   logic [31:0] addr_q, addr_d;
   logic [1:0]  error_q, error_d;
`ifdef UART_LOADER_CHECKSUM_EN
   logic [7:0]  csum_q, csum_d;
   logic        csum_bad_q, csum_bad_d;
   logic        bad;
`endif

   logic [31:0] len_next;
   logic [31:0] asm_next;
   logic        last_byte;
   logic        word_done;
   logic        wb_full;
   logic        wb_load;
   logic        can_load;

   // Byte merge helpers: header byte into len, payload byte into its lane.
   always_comb begin
      len_next = len_q;
      len_next[{bidx_q, 3'b000} +: 8] = rx_data;
      asm_next = asm_q;
      asm_next[{cnt_q[1:0], 3'b000} +: 8] = rx_data;
      last_byte = ((cnt_q + 32'd1) == len_q);
      word_done = (cnt_q[1:0] == 2'b11) || last_byte;
      can_load  = !wb_full || mem.mem_ready;
   end

   // Loader FSM: header parse, word assembly, overrun detection, completion.
   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      bidx_d  = bidx_q;
      asm_d   = asm_q;
      addr_d  = addr_q;
      error_d = error_q;
      wb_load = 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
      csum_d     = csum_q;
      csum_bad_d = csum_bad_q;
      bad        = (rx_data != csum_q);
`endif
      case (state_q)
         S_IDLE, S_DONE, S_ERROR: begin
            if (start) begin
               state_d = S_LEN;
               error_d = ERR_NONE;
               addr_d  = BASE_ADDR;
               cnt_d   = 32'd0;
               bidx_d  = 2'd0;
               len_d   = 32'd0;
               asm_d   = 32'd0;
`ifdef UART_LOADER_CHECKSUM_EN
               csum_d     = 8'd0;
               csum_bad_d = 1'b0;
`endif
            end
         end
         S_LEN: begin
            if (rx_valid) begin
               len_d  = len_next;
               bidx_d = bidx_q + 2'd1;
               if (bidx_q == 2'd3) begin
                  if (len_next > MAX_BYTES) begin
                     state_d = S_ERROR;
                     error_d = ERR_LEN;
                  end else if (len_next == 32'd0) begin
                     state_d = S_AFTER;
                  end else begin
                     state_d = S_DATA;
                  end
               end
            end
         end
         S_DATA: begin
            if (rx_valid) begin
               cnt_d = cnt_q + 32'd1;
`ifdef UART_LOADER_CHECKSUM_EN
               csum_d = csum_q ^ rx_data;
`endif
               if (word_done) begin
                  if (can_load) begin
                     wb_load = 1'b1;
                     addr_d  = addr_q + 32'd4;
                     asm_d   = 32'd0;
                     if (last_byte) begin
                        state_d = S_AFTER;
                     end
                  end else begin
                     state_d = S_ERROR;
                     error_d = ERR_OVERRUN;
                  end
               end else begin
                  asm_d = asm_next;
               end
            end
         end
`ifdef UART_LOADER_CHECKSUM_EN
         S_CSUM: begin
            if (rx_valid) begin
               csum_bad_d = bad;
               if (can_load) begin
                  state_d = bad ? S_ERROR : S_DONE;
                  error_d = bad ? ERR_CSUM : error_q;
               end else begin
                  state_d = S_FLUSH;
               end
            end
         end
`endif
         S_FLUSH: begin
            if (can_load) begin
`ifdef UART_LOADER_CHECKSUM_EN
               if (csum_bad_q) begin
                  state_d = S_ERROR;
                  error_d = ERR_CSUM;
               end else begin
                  state_d = S_DONE;
               end
`else
               state_d = S_DONE;
`endif
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         len_q   <= 32'd0;
         cnt_q   <= 32'd0;
         bidx_q  <= 2'd0;
         asm_q   <= 32'd0;
         addr_q  <= BASE_ADDR;
         error_q <= ERR_NONE;
`ifdef UART_LOADER_CHECKSUM_EN
         csum_q     <= 8'd0;
         csum_bad_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         bidx_q  <= bidx_d;
         asm_q   <= asm_d;
         addr_q  <= addr_d;
         error_q <= error_d;
`ifdef UART_LOADER_CHECKSUM_EN
         csum_q     <= csum_d;
         csum_bad_q <= csum_bad_d;
`endif
      end
   end

   uart_loader_wbuf #(
      .BASE_ADDR (BASE_ADDR)
   ) u_wbuf (
      .clk       (clk),
      .reset     (reset),
      .load      (wb_load),
      .addr      (addr_q),
      .data      (asm_next),
      .mask      (lane_mask(cnt_q[1:0])),
      .full      (wb_full),
      .mem_valid (mem.mem_valid),
      .mem_ready (mem.mem_ready),
      .mem_addr  (mem.mem_addr),
      .mem_wdata (mem.mem_wdata),
      .mem_wmask (mem.mem_wmask)
   );

   assign busy  = (state_q == S_LEN) || (state_q == S_DATA) ||
                  (state_q == S_CSUM) || (state_q == S_FLUSH);
   assign done  = (state_q == S_DONE);
   assign error = error_q;

endmodule

// File: tb/tb_uart_loader.sv
// tb/tb_uart_loader.sv - directed self-checking bench for uart_loader
module tb_uart_loader;

   localparam logic [31:0] BASE = 32'h1000_0000;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] rx_data = 8'd0;
   logic       rx_valid = 1'b0;
   logic       start = 1'b0;
   logic       busy;
   logic       done;
   logic [1:0] error;

   int checks = 0;
   int errors = 0;
   int n0;

   logic [31:0] wa[$];
   logic [31:0] wd[$];
   logic [3:0]  wm[$];

   uart_loader_if mem_if ();

   uart_loader #(
      .BASE_ADDR (BASE),
      .MAX_BYTES (32'h0001_0000)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .start    (start),
      .mem      (mem_if),
      .busy     (busy),
      .done     (done),
      .error    (error)
   );

   always #5 clk = ~clk;

   // Record every accepted write, sampled mid-cycle.
   always @(negedge clk) begin
      if (!reset && mem_if.mem_valid && mem_if.mem_ready) begin
         wa.push_back(mem_if.mem_addr);
         wd.push_back(mem_if.mem_wdata);
         wm.push_back(mem_if.mem_wmask);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_data  = b;
      tick();
      rx_valid = 1'b0;
   endtask

   task automatic send_len(input logic [31:0] len);
      send_byte(len[7:0]);
      send_byte(len[15:8]);
      send_byte(len[23:16]);
      send_byte(len[31:24]);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send_csum(input logic [7:0] b);
`ifdef UART_LOADER_CHECKSUM_EN
      send_byte(b);
`else
      if (b == 8'hxx) tick();
`endif
   endtask

   task automatic wait_end(input string tag);
      int n = 0;
      while (!(done || (error != 2'd0)) && n < 50) begin
         tick();
         n++;
      end
      chk(tag, {31'd0, done || (error != 2'd0)}, 32'd1);
   endtask

   task automatic chk_wr(input int idx, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
      chk("wr_addr", (idx < wa.size()) ? wa[idx] : 32'hdead_beef, a);
      chk("wr_data", (idx < wd.size()) ? wd[idx] : 32'hdead_beef, d);
      chk("wr_mask", (idx < wm.size()) ? 32'(wm[idx]) : 32'hdead_beef, 32'(m));
   endtask

   initial begin
      mem_if.mem_ready = 1'b1;
      tick();
      tick();
      reset = 1'b0;

      // Reset state
      chk("rst_valid", 32'(mem_if.mem_valid), 32'd0);
      chk("rst_addr", mem_if.mem_addr, BASE);
      chk("rst_wdata", mem_if.mem_wdata, 32'd0);
      chk("rst_wmask", 32'(mem_if.mem_wmask), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_error", 32'(error), 32'd0);

      // rx bytes before start are ignored
      send_byte(8'h55);
      chk("idle_busy", 32'(busy), 32'd0);

      // Basic load
      n0 = wa.size();
      pulse_start();
      chk("basic_busy", 32'(busy), 32'd1);
      send_len(32'd8);
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
      send_byte(8'h55); send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
`ifndef UART_LOADER_CHECKSUM_EN
      chk("basic_last_valid", 32'(mem_if.mem_valid), 32'd1);
      chk("basic_last_done", 32'(done), 32'd0);
      tick();
      chk("basic_done_edge", 32'(done), 32'd1);
      chk("basic_busy_fall", 32'(busy), 32'd0);
`endif
      send_csum(8'h88);
      wait_end("basic_end");
      chk("basic_done", 32'(done), 32'd1);
      chk("basic_error", 32'(error), 32'd0);
      chk("basic_count", 32'(wa.size() - n0), 32'd2);
      chk_wr(n0, BASE, 32'h4433_2211, 4'hF);
      chk_wr(n0 + 1, BASE + 32'd4, 32'h8877_6655, 4'hF);

      // Partial word
      n0 = wa.size();
      pulse_start();
      chk("partial_done_clr", 32'(done), 32'd0);
      send_len(32'd5);
      send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD); send_byte(8'hEE);
      send_csum(8'hEE);
      wait_end("partial_end");
      chk("partial_done", 32'(done), 32'd1);
      chk("partial_count", 32'(wa.size() - n0), 32'd2);
      chk_wr(n0, BASE, 32'hDDCC_BBAA, 4'hF);
      chk_wr(n0 + 1, BASE + 32'd4, 32'h0000_00EE, 4'h1);

      // Zero length
      n0 = wa.size();
      pulse_start();
      send_len(32'd0);
      send_csum(8'h00);
      wait_end("zero_end");
      chk("zero_done", 32'(done), 32'd1);
      chk("zero_error", 32'(error), 32'd0);
      chk("zero_count", 32'(wa.size() - n0), 32'd0);

      // Oversize, then recovery
      n0 = wa.size();
      pulse_start();
      send_len(32'h0001_0001);
      chk("over_error", 32'(error), 32'd1);
      chk("over_busy", 32'(busy), 32'd0);
      chk("over_done", 32'(done), 32'd0);
      tick();
      chk("over_count", 32'(wa.size() - n0), 32'd0);
      pulse_start();
      chk("over_clr", 32'(error), 32'd0);
      send_len(32'd4);
      send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
      send_csum(8'h04);
      wait_end("recover_end");
      chk("recover_done", 32'(done), 32'd1);
      chk("recover_count", 32'(wa.size() - n0), 32'd1);
      chk_wr(n0, BASE, 32'h0403_0201, 4'hF);

      // Overrun with memory stalled
      n0 = wa.size();
      mem_if.mem_ready = 1'b0;
      pulse_start();
      send_len(32'd8);
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
      send_byte(8'h55); send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
      chk("ovr_error", 32'(error), 32'd2);
      chk("ovr_busy", 32'(busy), 32'd0);
      chk("ovr_valid", 32'(mem_if.mem_valid), 32'd1);
      tick(); tick(); tick();
      chk("ovr_hold_valid", 32'(mem_if.mem_valid), 32'd1);
      chk("ovr_hold_addr", mem_if.mem_addr, BASE);
      chk("ovr_hold_data", mem_if.mem_wdata, 32'h4433_2211);
      chk("ovr_hold_mask", 32'(mem_if.mem_wmask), 32'hF);
      mem_if.mem_ready = 1'b1;
      tick();
      chk("ovr_drain_valid", 32'(mem_if.mem_valid), 32'd0);
      chk("ovr_count", 32'(wa.size() - n0), 32'd1);
      chk_wr(n0, BASE, 32'h4433_2211, 4'hF);
      chk("ovr_error_hold", 32'(error), 32'd2);

      // Stall relieved in the completing cycle
      n0 = wa.size();
      mem_if.mem_ready = 1'b0;
      pulse_start();
      send_len(32'd8);
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
      send_byte(8'h55); send_byte(8'h66); send_byte(8'h77);
      mem_if.mem_ready = 1'b1;
      send_byte(8'h88);
      chk("pulse_error", 32'(error), 32'd0);
      send_csum(8'h88);
      wait_end("pulse_end");
      chk("pulse_done", 32'(done), 32'd1);
      chk("pulse_count", 32'(wa.size() - n0), 32'd2);
      chk_wr(n0 + 1, BASE + 32'd4, 32'h8877_6655, 4'hF);

`ifdef UART_LOADER_CHECKSUM_EN
      // Checksum match
      n0 = wa.size();
      pulse_start();
      send_len(32'd3);
      send_byte(8'h01); send_byte(8'h02); send_byte(8'h04);
      send_byte(8'h07);
      wait_end("csum_ok_end");
      chk("csum_ok_done", 32'(done), 32'd1);
      chk("csum_ok_error", 32'(error), 32'd0);
      chk_wr(n0, BASE, 32'h0004_0201, 4'h7);

      // Checksum mismatch
      n0 = wa.size();
      pulse_start();
      send_len(32'd3);
      send_byte(8'h01); send_byte(8'h02); send_byte(8'h04);
      send_byte(8'h06);
      wait_end("csum_bad_end");
      chk("csum_bad_error", 32'(error), 32'd3);
      chk("csum_bad_done", 32'(done), 32'd0);
      chk("csum_bad_count", 32'(wa.size() - n0), 32'd1);
`endif

      // Reset in the middle of DATA
      mem_if.mem_ready = 1'b0;
      pulse_start();
      send_len(32'd8);
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44); send_byte(8'h55);
      chk("mid_valid", 32'(mem_if.mem_valid), 32'd1);
      chk("mid_busy", 32'(busy), 32'd1);
      reset = 1'b1;
      tick();
      chk("mrst_valid", 32'(mem_if.mem_valid), 32'd0);
      chk("mrst_addr", mem_if.mem_addr, BASE);
      chk("mrst_wdata", mem_if.mem_wdata, 32'd0);
      chk("mrst_wmask", 32'(mem_if.mem_wmask), 32'd0);
      chk("mrst_busy", 32'(busy), 32'd0);
      chk("mrst_done", 32'(done), 32'd0);
      chk("mrst_error", 32'(error), 32'd0);
      reset = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
